uart_fifo: RTL
==============

// Module: uart_fifo
// PURPOSE
//  Synchronous FIFO between the UART receiver and the RX loopback/test controller (same
//  block instantiated between test controller and transmitter on the TX side). Buffers
//  bytes from the producer's write strobe and presents the oldest byte first-word-fall-
//  through on r_data, with empty/full flags driving the consumer's rd/wr handshake.
// PARAMETERS
//  B   8   data width in bits
//  W   4   address width; depth = 2**W entries (16)
// PORTS
//  clk        in   1    system clock, all state on rising edge
//  reset_n    in   1    asynchronous active-low reset
//  wr         in   1    write strobe; pushes w_data this cycle if accepted
//  w_data     in   B    write data
//  rd         in   1    read strobe; pops head entry this cycle if accepted
//  r_data     out  B    head entry (FWFT); valid whenever empty==0
//  empty      out  1    1 = no entries
//  full       out  1    1 = 2**W entries
//  count      out  W+1  current occupancy, 0..2**W
//  overflow   out  1    sticky: wr while full and no accepted rd
//  underflow  out  1    sticky: rd while empty
// BEHAVIOUR
//  - Reset (async, reset_n=0): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overflow=0,
//    underflow=0. Storage array NOT cleared; r_data undefined-but-stable until first write.
//  - Reset mid-operation: all contents discarded immediately; flags as above.
//  - Pointers W bits, increment mod 2**W (15 -> 0 wrap). count is W+1 bits.
//  - Accept rules per cycle (evaluated on pre-edge flags):
//     rd & !empty -> pop: rd_ptr+1.   rd & empty -> ignored, underflow<=1.
//     wr & !full  -> push: mem[wr_ptr]<=w_data, wr_ptr+1.
//     wr & full & rd -> push and pop both accepted (occupancy stays 2**W).
//     wr & full & !rd -> write dropped, overflow<=1, contents unchanged.
//     wr & empty & rd -> push only; rd ignored and underflow<=1.
//  - Flags registered, updated same edge as pointers:
//     push only: empty<=0; full<=(count==2**W-1). pop only: full<=0; empty<=(count==1).
//     push+pop: flags unchanged. count tracks +1/-1/0 accordingly.
//  - r_data = mem[rd_ptr] combinationally (FWFT). Latency write->visible: byte written at
//    edge N appears on r_data and empty=0 after edge N (one cycle). Pop at edge N exposes
//    next entry after edge N.
//  - Consumer contract: a controller that registers rd and samples r_data the cycle after
//    asserting rd must sample before the pop edge; the FIFO itself holds r_data stable while
//    rd==0.
//  - overflow/underflow clear only on reset.
//  - No X propagation on flags; rd/wr treated as level strobes, one entry per cycle max.
// STRUCTURE
//  - Shared include uart_defs.vh: `define UART_DBIT 8, `define UART_FIFO_W 4, used by
//    uart_rx, uart_tx, uart_fifo and the test controller for consistent widths.
//  - Sub-module fifo_ctrl (W): pointers, count, empty/full, overflow/underflow, outputs
//    wr_addr, rd_addr, wr_en. Top uart_fifo = fifo_ctrl + B x 2**W register file
//    (write on wr_en, asynchronous read at rd_addr).
// TESTING
//  1 reset_n=0 mid-stream after 5 writes -> empty=1 full=0 count=0 overflow=underflow=0
//    asynchronously, before next clk edge.
//  2 write 0x41,0x42,0x43 on 3 edges -> 1 cycle after first, r_data=0x41 empty=0; count=3;
//    three rd pops return 0x41,0x42,0x43 then empty=1.
//  3 write 16 bytes 0x00..0x0F -> full=1 count=16; 17th wr 0xAA -> dropped, overflow=1;
//    pops return 0x00..0x0F in order, 0xAA never appears.
//  4 full, assert rd&wr with 0x55 -> full stays 1, count=16, head advances; 0x55 read last
//    after 15 more pops.
//  5 empty, assert rd&wr with 0x7E -> count=1 empty=0 r_data=0x7E underflow=1; rd alone on
//    empty later -> no pointer change.
//  6 40 interleaved push/pop cycles crossing pointer wrap 15->0 twice -> scoreboard order
//    match, count always equals pushes-pops.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - shared UART widths and FIFO per-cycle operation encoding
package uart_fifo_pkg;

  localparam int UART_DBIT   = 8;
  localparam int UART_FIFO_W = 4;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return OP_PUSH;
      2'b01:   return OP_POP;
      2'b11:   return OP_BOTH;
      default: return OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO pointers, occupancy, registered empty/full and sticky error flags
module fifo_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int W = UART_FIFO_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr,
  input  logic         rd,
  output logic [W-1:0] wr_addr,
  output logic [W-1:0] rd_addr,
  output logic         wr_en,
  output logic         empty,
  output logic         full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [W:0] DEPTH = (W+1)'(1) << W;

  logic [W-1:0] wr_ptr;
  logic [W-1:0] rd_ptr;
  logic         push;
  logic         pop;
  fifo_op_e     op;

  // A write into a full FIFO is still accepted when a pop frees the slot on the same edge.
  assign pop     = rd & ~empty;
  assign push    = wr & (~full | rd);
  assign op      = fifo_op(push, pop);
  assign wr_en   = push;
  assign wr_addr = wr_ptr;
  assign rd_addr = rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (rd && empty)
        underflow <= 1'b1;
      if (wr && full && !rd)
        overflow <= 1'b1;
      case (op)
        OP_PUSH: begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
          empty  <= 1'b0;
          full   <= (count == DEPTH - 1'b1);
        end
        OP_POP: begin
          rd_ptr <= rd_ptr + 1'b1;
          count  <= count - 1'b1;
          full   <= 1'b0;
          empty  <= (count == (W+1)'(1));
        end
        OP_BOTH: begin
          wr_ptr <= wr_ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        OP_IDLE: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - first-word-fall-through byte FIFO between UART and test controller
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int B = UART_DBIT,
  parameter int W = UART_FIFO_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  logic [B-1:0] mem [0:(1<<W)-1];
  logic [W-1:0] wr_addr;
  logic [W-1:0] rd_addr;
  logic         wr_en;

  fifo_ctrl #(.W(W)) u_ctrl (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr        (wr),
    .rd        (rd),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .wr_en     (wr_en),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= w_data;
  end

  assign r_data = mem[rd_addr];

endmodule
